vend_ctrl_param: RTL and testbench

Parametrised vending-machine transaction controller: the next-generation core behind the vending top level. It generalises the fixed 4-product, fixed-price machine to NUM_PRODUCTS products with per-product prices, tracked stock and sold-out flags. It also adds a capped credit register, coin rejection, an inactivity refund timeout and an acknowledged change handshake. Display and LED decoding remain in the top level, driven from `state_out`, `credit` and `sold_out`.

---
 rtl/vend_ctrl_param.sv | 226 ++++++++++++++++++++++
 tb/tb_vend_ctrl_param.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_ctrl_param.sv
// Parametrised vending transaction controller: credit accumulation, per-product
// pricing and stock, sold-out tracking, inactivity refund and acknowledged change.
module vend_ctrl_param #(
   parameter int NUM_PRODUCTS = 4,
   parameter int CREDIT_W     = 8,
   parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES = {8'd25, 8'd20, 8'd15, 8'd10},
   parameter int MAX_CREDIT   = 50,
   parameter int COIN1_VAL    = 1,
   parameter int COIN2_VAL    = 5,
   parameter int COIN3_VAL    = 10,
   parameter int STOCK_W      = 4,
   parameter int INIT_STOCK   = 4,
   parameter int TIMEOUT_CYC  = 1000,
   localparam int SEL_W       = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              coin_in,
   input  logic                    sel_valid,
   input  logic [SEL_W-1:0]        product_sel,
   input  logic                    cancel,
   input  logic                    restock,
   input  logic [SEL_W-1:0]        restock_id,
   input  logic [STOCK_W-1:0]      restock_qty,
   input  logic                    change_ack,
   output logic [2:0]              state_out,
   output logic [CREDIT_W-1:0]     credit,
   output logic                    coin_reject,
   output logic                    insufficient,
   output logic                    sold_out_hit,
   output logic                    vend_valid,
   output logic [SEL_W-1:0]        vend_id,
   output logic                    change_valid,
   output logic [CREDIT_W-1:0]     change_amt,
   output logic [NUM_PRODUCTS-1:0] sold_out
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CREDIT = 3'd1;
   localparam logic [2:0] ST_VEND   = 3'd2;
   localparam logic [2:0] ST_CHANGE = 3'd3;

   localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [TMR_W-1:0]    TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [CREDIT_W:0]   MAX_C     = (CREDIT_W + 1)'(MAX_CREDIT);
   localparam logic [STOCK_W:0]    STOCK_MAX = {1'b0, {STOCK_W{1'b1}}};

   logic [2:0]              state_q, state_d;
   logic [CREDIT_W-1:0]     credit_q, credit_d;
   logic [CREDIT_W-1:0]     change_amt_q, change_amt_d;
   logic                    change_valid_q, change_valid_d;
   logic                    vend_valid_q, vend_valid_d;
   logic [SEL_W-1:0]        vend_id_q, vend_id_d;
   logic                    coin_reject_q, coin_reject_d;
   logic                    insufficient_q, insufficient_d;
   logic                    sold_out_hit_q, sold_out_hit_d;
   logic [TMR_W-1:0]        tmr_q, tmr_d;
   logic [STOCK_W-1:0]      stock_q [NUM_PRODUCTS];
   logic [STOCK_W-1:0]      stock_d [NUM_PRODUCTS];

   logic [CREDIT_W-1:0]     price_a [NUM_PRODUCTS];
   logic [CREDIT_W-1:0]     price_sel;
   logic [STOCK_W-1:0]      stock_sel;
   logic [CREDIT_W-1:0]     coin_val;
   logic [CREDIT_W:0]       coin_sum;
   logic                    coin_present, coin_fits;
   logic                    sel_in_range, sel_act, sel_soldout, sel_insuf;
   logic                    timeout_hit;
   logic                    vend_go;
   logic [STOCK_W:0]        st_sum;

   for (genvar g = 0; g < NUM_PRODUCTS; g++) begin : g_prod
      assign price_a[g]  = PRICES[g*CREDIT_W +: CREDIT_W];
      assign sold_out[g] = (stock_q[g] == '0);
   end

   always_comb begin
      price_sel = '0;
      stock_sel = '0;
      for (int i = 0; i < NUM_PRODUCTS; i++) begin
         if (product_sel == SEL_W'(i)) begin
            price_sel = price_a[i];
            stock_sel = stock_q[i];
         end
      end
   end

   always_comb begin
      case (coin_in)
         2'b01:   coin_val = CREDIT_W'(COIN1_VAL);
         2'b10:   coin_val = CREDIT_W'(COIN2_VAL);
         2'b11:   coin_val = CREDIT_W'(COIN3_VAL);
         default: coin_val = '0;
      endcase
   end

   // The extra sum bit keeps a near-full credit plus a large coin from wrapping past the cap.
   assign coin_present = (coin_in != 2'b00);
   assign coin_sum     = {1'b0, credit_q} + {1'b0, coin_val};
   assign coin_fits    = (coin_sum <= MAX_C);

   assign sel_in_range = (32'(product_sel) < 32'(NUM_PRODUCTS));
   assign sel_act      = sel_valid && sel_in_range;
   assign sel_soldout  = sel_act && (stock_sel == '0);
   assign sel_insuf    = sel_act && !sel_soldout && (credit_q < price_sel);
   assign timeout_hit  = (tmr_q == TMR_LAST);

   always_comb begin
      state_d        = state_q;
      credit_d       = credit_q;
      change_valid_d = change_valid_q;
      change_amt_d   = change_amt_q;
      vend_valid_d   = 1'b0;
      vend_id_d      = vend_id_q;
      coin_reject_d  = 1'b0;
      insufficient_d = 1'b0;
      sold_out_hit_d = 1'b0;
      vend_go        = 1'b0;
      tmr_d          = (state_q == ST_CREDIT) ? tmr_q + TMR_W'(1) : '0;

      case (state_q)
         ST_IDLE, ST_CREDIT: begin
            if ((state_q == ST_CREDIT) && (cancel || timeout_hit)) begin
               state_d        = ST_CHANGE;
               change_valid_d = 1'b1;
               change_amt_d   = credit_q;
               coin_reject_d  = coin_present;
            end else if (sel_act) begin
               // An acted-on selection owns the cycle, so a coin alongside it bounces.
               coin_reject_d = coin_present;
               if (sel_soldout) begin
                  sold_out_hit_d = 1'b1;
                  tmr_d          = '0;
               end else if (sel_insuf) begin
                  insufficient_d = 1'b1;
                  tmr_d          = '0;
               end else begin
                  vend_go      = 1'b1;
                  vend_valid_d = 1'b1;
                  vend_id_d    = product_sel;
                  credit_d     = credit_q - price_sel;
                  state_d      = ST_VEND;
               end
            end else if (coin_present) begin
               if (coin_fits) begin
                  credit_d = coin_sum[CREDIT_W-1:0];
                  state_d  = ST_CREDIT;
                  tmr_d    = '0;
               end else begin
                  coin_reject_d = 1'b1;
               end
            end
         end
         ST_VEND: begin
            coin_reject_d = coin_present;
            if (credit_q != '0) begin
               state_d        = ST_CHANGE;
               change_valid_d = 1'b1;
               change_amt_d   = credit_q;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CHANGE: begin
            coin_reject_d = coin_present;
            if (change_ack) begin
               state_d        = ST_IDLE;
               credit_d       = '0;
               change_valid_d = 1'b0;
               change_amt_d   = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Restock and a dispense of the same product on one edge combine before saturating.
   always_comb begin
      st_sum = '0;
      for (int i = 0; i < NUM_PRODUCTS; i++) begin
         st_sum = {1'b0, stock_q[i]};
         if (vend_go && (product_sel == SEL_W'(i))) st_sum = st_sum - (STOCK_W + 1)'(1);
         if (restock && (restock_id == SEL_W'(i))) st_sum = st_sum + {1'b0, restock_qty};
         stock_d[i] = (st_sum > STOCK_MAX) ? {STOCK_W{1'b1}} : st_sum[STOCK_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         credit_q       <= '0;
         change_valid_q <= 1'b0;
         change_amt_q   <= '0;
         vend_valid_q   <= 1'b0;
         vend_id_q      <= '0;
         coin_reject_q  <= 1'b0;
         insufficient_q <= 1'b0;
         sold_out_hit_q <= 1'b0;
         tmr_q          <= '0;
         for (int i = 0; i < NUM_PRODUCTS; i++) stock_q[i] <= STOCK_W'(INIT_STOCK);
      end else begin
         state_q        <= state_d;
         credit_q       <= credit_d;
         change_valid_q <= change_valid_d;
         change_amt_q   <= change_amt_d;
         vend_valid_q   <= vend_valid_d;
         vend_id_q      <= vend_id_d;
         coin_reject_q  <= coin_reject_d;
         insufficient_q <= insufficient_d;
         sold_out_hit_q <= sold_out_hit_d;
         tmr_q          <= tmr_d;
         for (int i = 0; i < NUM_PRODUCTS; i++) stock_q[i] <= stock_d[i];
      end
   end

   assign state_out    = state_q;
   assign credit       = credit_q;
   assign change_valid = change_valid_q;
   assign change_amt   = change_amt_q;
   assign vend_valid   = vend_valid_q;
   assign vend_id      = vend_id_q;
   assign coin_reject  = coin_reject_q;
   assign insufficient = insufficient_q;
   assign sold_out_hit = sold_out_hit_q;

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Scenario bench for vend_ctrl_param: scoreboard queues hold expected dispense ids
// and change amounts, popped when the controller presents them.
module tb_vend_ctrl_param;
   localparam int NP = 4;
   localparam int CW = 8;
   localparam int SW = 2;
   localparam int STW = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [1:0]     coin_in;
   logic           sel_valid;
   logic [SW-1:0]  product_sel;
   logic           cancel;
   logic           restock;
   logic [SW-1:0]  restock_id;
   logic [STW-1:0] restock_qty;
   logic           change_ack;
   logic [2:0]     state_out;
   logic [CW-1:0]  credit;
   logic           coin_reject;
   logic           insufficient;
   logic           sold_out_hit;
   logic           vend_valid;
   logic [SW-1:0]  vend_id;
   logic           change_valid;
   logic [CW-1:0]  change_amt;
   logic [NP-1:0]  sold_out;

   int n_pass  = 0;
   int n_total = 0;
   logic [SW-1:0] exp_vend_q[$];
   logic [CW-1:0] exp_chg_q[$];
   int price_m[NP] = '{10, 15, 20, 25};
   int stock_m[NP];

   always #5 clk = ~clk;

   vend_ctrl_param #(.TIMEOUT_CYC(8)) dut (
      .clk(clk), .rst(rst), .coin_in(coin_in), .sel_valid(sel_valid),
      .product_sel(product_sel), .cancel(cancel), .restock(restock),
      .restock_id(restock_id), .restock_qty(restock_qty), .change_ack(change_ack),
      .state_out(state_out), .credit(credit), .coin_reject(coin_reject),
      .insufficient(insufficient), .sold_out_hit(sold_out_hit), .vend_valid(vend_valid),
      .vend_id(vend_id), .change_valid(change_valid), .change_amt(change_amt),
      .sold_out(sold_out)
   );

   // Driver tasks: inputs change 1 time unit after a rising edge, outputs are read there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      coin_in = 2'b00; sel_valid = 1'b0; product_sel = '0; cancel = 1'b0;
      restock = 1'b0; restock_id = '0; restock_qty = '0; change_ack = 1'b0;
   endtask

   task automatic drive_coin(input logic [1:0] code);
      coin_in = code; tick(); coin_in = 2'b00;
   endtask

   task automatic drive_sel(input logic [SW-1:0] p);
      sel_valid = 1'b1; product_sel = p; tick(); sel_valid = 1'b0;
   endtask

   task automatic drive_cancel();
      cancel = 1'b1; tick(); cancel = 1'b0;
   endtask

   task automatic drive_ack();
      change_ack = 1'b1; tick(); change_ack = 1'b0;
   endtask

   task automatic drive_restock(input logic [SW-1:0] id, input logic [STW-1:0] qty);
      restock = 1'b1; restock_id = id; restock_qty = qty; tick(); restock = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      for (int i = 0; i < NP; i++) stock_m[i] = 4;
      n_total++;
      if (state_out !== 3'd0 || credit !== '0) $display("FAIL reset_state: state=%0d credit=%0d want 0/0", state_out, credit);
      else n_pass++;
      n_total++;
      if ({coin_reject, insufficient, sold_out_hit, vend_valid, change_valid} !== 5'b0)
         $display("FAIL reset_pulses: got %b want 00000", {coin_reject, insufficient, sold_out_hit, vend_valid, change_valid});
      else n_pass++;
      n_total++;
      if (change_amt !== '0 || vend_id !== '0 || sold_out !== '0)
         $display("FAIL reset_regs: amt=%0d id=%0d sold_out=%b want 0/0/0000", change_amt, vend_id, sold_out);
      else n_pass++;
   endtask

   task automatic test_coins();
      logic [1:0]    codes [3] = '{2'b10, 2'b10, 2'b11};
      logic [CW-1:0] exp_c [3] = '{8'd5, 8'd10, 8'd20};
      for (int i = 0; i < 3; i++) begin
         drive_coin(codes[i]);
         n_total++;
         if (credit !== exp_c[i] || coin_reject !== 1'b0) $display("FAIL coin_credit[%0d]: credit=%0d rej=%b want %0d/0", i, credit, coin_reject, exp_c[i]);
         else n_pass++;
      end
      n_total++;
      if (state_out !== 3'd1) $display("FAIL coin_state: got %0d want 1", state_out);
      else n_pass++;
   endtask

   task automatic test_vend();
      logic [SW-1:0] ev;
      logic [CW-1:0] ea;
      exp_vend_q.push_back(2'd1);
      exp_chg_q.push_back(8'd5);
      drive_sel(2'd1);
      stock_m[1]--;
      n_total++;
      if (vend_valid !== 1'b1 || exp_vend_q.size() == 0) $display("FAIL vend_seen: vend_valid=%b want 1", vend_valid);
      else begin
         ev = exp_vend_q.pop_front();
         if (vend_id !== ev) $display("FAIL vend_id: got %0d want %0d", vend_id, ev);
         else n_pass++;
      end
      n_total++;
      if (credit !== 8'd5 || state_out !== 3'd2) $display("FAIL vend_credit: credit=%0d state=%0d want 5/2", credit, state_out);
      else n_pass++;
      tick();
      n_total++;
      if (vend_valid !== 1'b0 || change_valid !== 1'b1 || exp_chg_q.size() == 0)
         $display("FAIL vend_change_seen: vend_valid=%b change_valid=%b want 0/1", vend_valid, change_valid);
      else begin
         ea = exp_chg_q.pop_front();
         if (change_amt !== ea) $display("FAIL vend_change_amt: got %0d want %0d", change_amt, ea);
         else n_pass++;
      end
      tick();
      n_total++;
      if (change_valid !== 1'b1 || change_amt !== 8'd5 || state_out !== 3'd3)
         $display("FAIL change_hold: valid=%b amt=%0d state=%0d want 1/5/3", change_valid, change_amt, state_out);
      else n_pass++;
      drive_ack();
      n_total++;
      if (state_out !== 3'd0 || credit !== '0 || change_valid !== 1'b0 || change_amt !== '0)
         $display("FAIL ack_idle: state=%0d credit=%0d valid=%b amt=%0d want 0/0/0/0", state_out, credit, change_valid, change_amt);
      else n_pass++;
   endtask

   task automatic test_insufficient();
      logic [CW-1:0] ea;
      drive_sel(2'd0);
      n_total++;
      if (insufficient !== 1'b1 || state_out !== 3'd0) $display("FAIL insuf_idle: insuf=%b state=%0d want 1/0", insufficient, state_out);
      else n_pass++;
      drive_coin(2'b11);
      drive_sel(2'd3);
      n_total++;
      if (insufficient !== 1'b1 || credit !== 8'd10 || vend_valid !== 1'b0)
         $display("FAIL insuf_credit: insuf=%b credit=%0d vend=%b want 1/10/0", insufficient, credit, vend_valid);
      else n_pass++;
      tick();
      n_total++;
      if (insufficient !== 1'b0) $display("FAIL insuf_width: got %b want 0", insufficient);
      else n_pass++;
      exp_chg_q.push_back(8'd10);
      drive_cancel();
      n_total++;
      if (change_valid !== 1'b1 || state_out !== 3'd3 || exp_chg_q.size() == 0)
         $display("FAIL cancel_change_seen: valid=%b state=%0d want 1/3", change_valid, state_out);
      else begin
         ea = exp_chg_q.pop_front();
         if (change_amt !== ea) $display("FAIL cancel_change_amt: got %0d want %0d", change_amt, ea);
         else n_pass++;
      end
      drive_ack();
   endtask

   task automatic test_reject();
      logic [CW-1:0] ea;
      for (int i = 0; i < 4; i++) drive_coin(2'b11);
      drive_coin(2'b10);
      n_total++;
      if (credit !== 8'd45) $display("FAIL cap_fill: credit=%0d want 45", credit);
      else n_pass++;
      drive_coin(2'b11);
      n_total++;
      if (coin_reject !== 1'b1 || credit !== 8'd45) $display("FAIL cap_reject: rej=%b credit=%0d want 1/45", coin_reject, credit);
      else n_pass++;
      exp_chg_q.push_back(8'd45);
      coin_in = 2'b11; cancel = 1'b1; tick(); coin_in = 2'b00; cancel = 1'b0;
      n_total++;
      if (coin_reject !== 1'b1 || change_valid !== 1'b1 || exp_chg_q.size() == 0)
         $display("FAIL cancel_coin: rej=%b valid=%b want 1/1", coin_reject, change_valid);
      else begin
         ea = exp_chg_q.pop_front();
         if (change_amt !== ea) $display("FAIL cancel_coin_amt: got %0d want %0d", change_amt, ea);
         else n_pass++;
      end
      drive_coin(2'b01);
      n_total++;
      if (coin_reject !== 1'b1 || credit !== 8'd45 || change_amt !== 8'd45)
         $display("FAIL change_coin: rej=%b credit=%0d amt=%0d want 1/45/45", coin_reject, credit, change_amt);
      else n_pass++;
      drive_ack();
   endtask

   task automatic test_sold_out();
      logic [SW-1:0] ev;
      for (int k = 0; k < 4; k++) begin
         drive_coin(2'b11);
         exp_vend_q.push_back(2'd0);
         drive_sel(2'd0);
         stock_m[0]--;
         n_total++;
         if (vend_valid !== 1'b1 || exp_vend_q.size() == 0) $display("FAIL so_vend[%0d]: vend_valid=%b want 1", k, vend_valid);
         else begin
            ev = exp_vend_q.pop_front();
            if (vend_id !== ev || credit !== '0) $display("FAIL so_vend_id[%0d]: id=%0d credit=%0d want %0d/0", k, vend_id, credit, ev);
            else n_pass++;
         end
         tick();
         n_total++;
         if (state_out !== 3'd0 || change_valid !== 1'b0) $display("FAIL so_no_change[%0d]: state=%0d valid=%b want 0/0", k, state_out, change_valid);
         else n_pass++;
      end
      n_total++;
      if (sold_out[0] !== (stock_m[0] == 0)) $display("FAIL so_flag: sold_out=%b want bit0=1", sold_out);
      else n_pass++;
      drive_coin(2'b11);
      drive_sel(2'd0);
      n_total++;
      if (sold_out_hit !== 1'b1 || vend_valid !== 1'b0 || credit !== 8'd10)
         $display("FAIL so_hit: hit=%b vend=%b credit=%0d want 1/0/10", sold_out_hit, vend_valid, credit);
      else n_pass++;
      drive_restock(2'd0, 4'd15);
      stock_m[0] = 15;
      n_total++;
      if (sold_out !== 4'b0000 || sold_out_hit !== 1'b0) $display("FAIL restock_flag: sold_out=%b hit=%b want 0000/0", sold_out, sold_out_hit);
      else n_pass++;
      exp_vend_q.push_back(2'd0);
      drive_sel(2'd0);
      stock_m[0]--;
      n_total++;
      if (vend_valid !== 1'b1 || exp_vend_q.size() == 0) $display("FAIL restock_vend: vend_valid=%b want 1", vend_valid);
      else begin
         ev = exp_vend_q.pop_front();
         if (vend_id !== ev) $display("FAIL restock_vend_id: got %0d want %0d", vend_id, ev);
         else n_pass++;
      end
      tick();
   endtask

   task automatic test_timeout();
      logic [CW-1:0] ea;
      drive_coin(2'b10);
      repeat (7) tick();
      n_total++;
      if (state_out !== 3'd1) $display("FAIL timeout_early: state=%0d want 1", state_out);
      else n_pass++;
      exp_chg_q.push_back(8'd5);
      tick();
      n_total++;
      if (change_valid !== 1'b1 || state_out !== 3'd3 || exp_chg_q.size() == 0)
         $display("FAIL timeout_fire: valid=%b state=%0d want 1/3", change_valid, state_out);
      else begin
         ea = exp_chg_q.pop_front();
         if (change_amt !== ea) $display("FAIL timeout_amt: got %0d want %0d", change_amt, ea);
         else n_pass++;
      end
      drive_ack();
      drive_coin(2'b10);
      repeat (5) tick();
      drive_sel(2'd0);
      n_total++;
      if (insufficient !== 1'b1) $display("FAIL timeout_insuf: got %b want 1", insufficient);
      else n_pass++;
      repeat (7) tick();
      n_total++;
      if (state_out !== 3'd1) $display("FAIL timeout_cleared: state=%0d want 1", state_out);
      else n_pass++;
      exp_chg_q.push_back(8'd5);
      tick();
      n_total++;
      if (change_valid !== 1'b1 || exp_chg_q.size() == 0) $display("FAIL timeout_refire: valid=%b want 1", change_valid);
      else begin
         ea = exp_chg_q.pop_front();
         if (change_amt !== ea) $display("FAIL timeout_refire_amt: got %0d want %0d", change_amt, ea);
         else n_pass++;
      end
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < NP; i++) stock_m[i] = 4;
      n_total++;
      if (state_out !== 3'd0 || change_valid !== 1'b0 || credit !== '0 || sold_out !== '0)
         $display("FAIL rst_in_change: state=%0d valid=%b credit=%0d sold_out=%b want 0/0/0/0000", state_out, change_valid, credit, sold_out);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [SW-1:0] ev;
      logic [CW-1:0] ea;
      logic [CW-1:0] chg;
      int p;
      for (int it = 0; it < 6; it++) begin
         p = $urandom_range(0, 2);
         drive_coin(2'b11);
         drive_coin(2'b11);
         n_total++;
         if (credit !== 8'd20) $display("FAIL b2b_credit[%0d]: got %0d want 20", it, credit);
         else n_pass++;
         if (stock_m[p] == 0) begin
            drive_sel(SW'(p));
            n_total++;
            if (sold_out_hit !== 1'b1) $display("FAIL b2b_soldout[%0d]: got %b want 1", it, sold_out_hit);
            else n_pass++;
            exp_chg_q.push_back(8'd20);
            drive_cancel();
         end else begin
            chg = CW'(20 - price_m[p]);
            exp_vend_q.push_back(SW'(p));
            if (chg != 0) exp_chg_q.push_back(chg);
            drive_sel(SW'(p));
            stock_m[p]--;
            n_total++;
            if (vend_valid !== 1'b1 || exp_vend_q.size() == 0) $display("FAIL b2b_vend[%0d]: vend_valid=%b want 1", it, vend_valid);
            else begin
               ev = exp_vend_q.pop_front();
               if (vend_id !== ev || credit !== chg) $display("FAIL b2b_vend_id[%0d]: id=%0d credit=%0d want %0d/%0d", it, vend_id, credit, ev, chg);
               else n_pass++;
            end
            tick();
         end
         if (exp_chg_q.size() != 0) begin
            n_total++;
            if (change_valid !== 1'b1) $display("FAIL b2b_change[%0d]: valid=%b want 1", it, change_valid);
            else begin
               ea = exp_chg_q.pop_front();
               if (change_amt !== ea) $display("FAIL b2b_change_amt[%0d]: got %0d want %0d", it, change_amt, ea);
               else n_pass++;
            end
            drive_ack();
         end
         n_total++;
         if (state_out !== 3'd0 || change_valid !== 1'b0) $display("FAIL b2b_idle[%0d]: state=%0d valid=%b want 0/0", it, state_out, change_valid);
         else n_pass++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_coins();
      test_vend();
      test_insufficient();
      test_reject();
      test_sold_out();
      test_timeout();
      test_back_to_back();
      n_total++;
      if (exp_vend_q.size() != 0 || exp_chg_q.size() != 0)
         $display("FAIL sb_drain: vend_left=%0d change_left=%0d want 0/0", exp_vend_q.size(), exp_chg_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
